// File: rtl/mod_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// mod_hazard_ctrl
//   Hazard controller for a 5-stage (IF/ID/EX/MEM/WB) pipeline. It sits beside
//   the datapath and drives every stage-register stall/flush enable:
//     - per-read-port operand forwarding select (MEM result beats WB result)
//     - load-use interlock inserting exactly LOAD_LAT bubbles
//     - full-pipe freeze while a data-memory access is outstanding, with a
//       sticky timeout flag once MEM_TOUT consecutive wait cycles elapse
//     - branch/jump flush of the two younger stages
//
// Optional feature (compile-time macro):
//   HAZARD_PERF_CNT_EN  - when defined, stall_cnt_o/flush_cnt_o are saturating
//                         performance counters; otherwise they are tied to 0.
//
// Ports
//   clk_i, rst_n_i                 clock, asynchronous active-low reset
//   rs_D_i / rs_E_i  [NRP*RAW]     ID / EX source registers, port p at [p*RAW +: RAW]
//   rd_E_i/rd_M_i/rd_W_i [RAW]     destination register of the EX/MEM/WB instruction
//   we_E_i/we_M_i/we_W_i           register write enable of the EX/MEM/WB instruction
//   mem_to_reg_E_i                 EX instruction is a load
//   mem_req_M_i, mem_ready_M_i     MEM-stage dmem access active / completing
//   b_taken_E_i                    branch/jump resolved taken in EX
//   fwd_sel_o [2*NRP]              per port: 00 reg file, 01 MEM, 10 WB
//   pc_stall_o, if2id_stall_o, id2ex_stall_o, ex2mem_stall_o   hold enables
//   if2id_flush_o, id2ex_flush_o, mem2wb_flush_o               bubble inserts
//   mem_tout_o                     sticky: MEM wait reached MEM_TOUT cycles
//   stall_cnt_o, flush_cnt_o [CNT_W]  performance counters
// ---------------------------------------------------------------------------
module mod_hazard_ctrl #(
    parameter int RAW      = 5,
    parameter int NRP      = 2,
    parameter int LOAD_LAT = 1,
    parameter int MEM_TOUT = 255,
    parameter int CNT_W    = 32
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NRP*RAW-1:0] rs_D_i,
    input  logic [NRP*RAW-1:0] rs_E_i,
    input  logic [RAW-1:0]     rd_E_i,
    input  logic [RAW-1:0]     rd_M_i,
    input  logic [RAW-1:0]     rd_W_i,
    input  logic               we_E_i,
    input  logic               we_M_i,
    input  logic               we_W_i,
    input  logic               mem_to_reg_E_i,
    input  logic               mem_req_M_i,
    input  logic               mem_ready_M_i,
    input  logic               b_taken_E_i,
    output logic [2*NRP-1:0]   fwd_sel_o,
    output logic               pc_stall_o,
    output logic               if2id_stall_o,
    output logic               id2ex_stall_o,
    output logic               ex2mem_stall_o,
    output logic               if2id_flush_o,
    output logic               id2ex_flush_o,
    output logic               mem2wb_flush_o,
    output logic               mem_tout_o,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]   flush_cnt_o
);

    // lu_cnt only ever holds LOAD_LAT-1; wait_cnt saturates at MEM_TOUT.
    localparam int LCW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam int WCW = $clog2(MEM_TOUT + 1);
    localparam logic [LCW-1:0] LU_INIT = LCW'(LOAD_LAT - 1);
    localparam logic [WCW-1:0] TOUT_V  = WCW'(MEM_TOUT);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_LU_WAIT = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [LCW-1:0] lu_cnt_q, lu_cnt_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           mem_tout_q, mem_tout_d;
    logic           freeze;
    logic           lu_hit;

    // A dmem access that has not completed freezes the whole pipe.
    assign freeze = mem_req_M_i && !mem_ready_M_i;

    // ------------------------------------------------------------------
    // Forwarding select. MEM holds the younger result, so it wins over WB.
    // Register 0 is hard-wired zero and is never forwarded. Outputs are
    // forced to 0 while reset is asserted.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        fwd_sel_o = '0;
        for (int p = 0; p < NRP; p++) begin
            if (rst_n_i && we_M_i && (rd_M_i != '0) && (rd_M_i == rs_E_i[p*RAW +: RAW]))
                fwd_sel_o[2*p +: 2] = 2'b01;
            else if (rst_n_i && we_W_i && (rd_W_i != '0) && (rd_W_i == rs_E_i[p*RAW +: RAW]))
                fwd_sel_o[2*p +: 2] = 2'b10;
        end
    end

    // Load in EX whose destination is read by the instruction in ID.
    always_comb begin
        lu_hit = 1'b0;
        if (mem_to_reg_E_i && we_E_i && (rd_E_i != '0)) begin
            for (int p = 0; p < NRP; p++) begin
                if (rs_D_i[p*RAW +: RAW] == rd_E_i)
                    lu_hit = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State register (FSM, bubble counter, MEM wait counter, timeout flag)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state_q    <= ST_RUN;
            lu_cnt_q   <= '0;
            wait_cnt_q <= '0;
            mem_tout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lu_cnt_q   <= lu_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            mem_tout_q <= mem_tout_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. A freeze holds the FSM and bubble counter so that
    // freeze cycles add to the load-use bubbles rather than consuming them.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        lu_cnt_d = lu_cnt_q;
        if (!freeze) begin
            case (state_q)
                ST_RUN: begin
                    // A taken branch kills the dependent consumer, so no interlock.
                    if (!b_taken_E_i && lu_hit && (LOAD_LAT > 1)) begin
                        state_d  = ST_LU_WAIT;
                        lu_cnt_d = LU_INIT;
                    end
                end
                ST_LU_WAIT: begin
                    if (b_taken_E_i) begin
                        state_d  = ST_RUN;
                        lu_cnt_d = '0;
                    end else begin
                        lu_cnt_d = lu_cnt_q - LCW'(1);
                        if (lu_cnt_q == LCW'(1))
                            state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d  = ST_RUN;
                    lu_cnt_d = '0;
                end
            endcase
        end

        // Consecutive wait cycles; any non-freeze cycle restarts the count.
        wait_cnt_d = '0;
        if (freeze)
            wait_cnt_d = (wait_cnt_q == TOUT_V) ? wait_cnt_q : wait_cnt_q + WCW'(1);
        mem_tout_d = mem_tout_q || (freeze && (wait_cnt_d == TOUT_V));
    end

    // ------------------------------------------------------------------
    // Output logic. Priority: freeze > branch > load-use.
    // ------------------------------------------------------------------
    always_comb begin
        pc_stall_o     = 1'b0;
        if2id_stall_o  = 1'b0;
        id2ex_stall_o  = 1'b0;
        ex2mem_stall_o = 1'b0;
        if2id_flush_o  = 1'b0;
        id2ex_flush_o  = 1'b0;
        mem2wb_flush_o = 1'b0;
        if (rst_n_i) begin
            if (freeze) begin
                // Hold IF..MEM; WB receives a bubble so a retired result is
                // not written twice.
                pc_stall_o     = 1'b1;
                if2id_stall_o  = 1'b1;
                id2ex_stall_o  = 1'b1;
                ex2mem_stall_o = 1'b1;
                mem2wb_flush_o = 1'b1;
            end else if (b_taken_E_i) begin
                if2id_flush_o = 1'b1;
                id2ex_flush_o = 1'b1;
            end else if ((state_q == ST_LU_WAIT) || lu_hit) begin
                pc_stall_o    = 1'b1;
                if2id_stall_o = 1'b1;
                id2ex_flush_o = 1'b1;
            end
        end
    end

    assign mem_tout_o = mem_tout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Both counters saturate at all-ones instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pc_stall_o && !(&stall_cnt_q))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (if2id_flush_o && !(&flush_cnt_q))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mod_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mod_hazard_ctrl
//   Two controllers share one set of inputs: u_dut0 with LOAD_LAT=2 and
//   u_dut1 with LOAD_LAT=1, both with MEM_TOUT=4. A behavioural model tracks
//   "bubbles still owed" per instance and the run length of MEM waits; every
//   falling edge all outputs of both instances are compared with it. Directed
//   scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_mod_hazard_ctrl;

    localparam int RAW = 5;
    localparam int NRP = 2;
    localparam int MT  = 4;
    localparam int CW  = 16;

    typedef struct packed {
        logic           pc_st;
        logic           if_st;
        logic           id_st;
        logic           ex_st;
        logic           if_fl;
        logic           id_fl;
        logic           wb_fl;
        logic [2*NRP-1:0] fwd;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [NRP*RAW-1:0] rs_D, rs_E;
    logic [RAW-1:0]     rd_E, rd_M, rd_W;
    logic               we_E, we_M, we_W;
    logic               mem_to_reg, mem_req, mem_ready, b_taken;

    logic [2*NRP-1:0] fwd   [2];
    logic             pc_st [2];
    logic             if_st [2];
    logic             id_st [2];
    logic             ex_st [2];
    logic             if_fl [2];
    logic             id_fl [2];
    logic             wb_fl [2];
    logic             tout  [2];
    logic [CW-1:0]    scnt  [2];
    logic [CW-1:0]    fcnt  [2];

    int n_checks = 0;
    int n_fail   = 0;

    mod_hazard_ctrl #(.RAW(RAW), .NRP(NRP), .LOAD_LAT(2), .MEM_TOUT(MT), .CNT_W(CW)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .rs_D_i(rs_D), .rs_E_i(rs_E),
        .rd_E_i(rd_E), .rd_M_i(rd_M), .rd_W_i(rd_W),
        .we_E_i(we_E), .we_M_i(we_M), .we_W_i(we_W),
        .mem_to_reg_E_i(mem_to_reg), .mem_req_M_i(mem_req), .mem_ready_M_i(mem_ready),
        .b_taken_E_i(b_taken), .fwd_sel_o(fwd[0]),
        .pc_stall_o(pc_st[0]), .if2id_stall_o(if_st[0]), .id2ex_stall_o(id_st[0]),
        .ex2mem_stall_o(ex_st[0]), .if2id_flush_o(if_fl[0]), .id2ex_flush_o(id_fl[0]),
        .mem2wb_flush_o(wb_fl[0]), .mem_tout_o(tout[0]),
        .stall_cnt_o(scnt[0]), .flush_cnt_o(fcnt[0])
    );

    mod_hazard_ctrl #(.RAW(RAW), .NRP(NRP), .LOAD_LAT(1), .MEM_TOUT(MT), .CNT_W(CW)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .rs_D_i(rs_D), .rs_E_i(rs_E),
        .rd_E_i(rd_E), .rd_M_i(rd_M), .rd_W_i(rd_W),
        .we_E_i(we_E), .we_M_i(we_M), .we_W_i(we_W),
        .mem_to_reg_E_i(mem_to_reg), .mem_req_M_i(mem_req), .mem_ready_M_i(mem_ready),
        .b_taken_E_i(b_taken), .fwd_sel_o(fwd[1]),
        .pc_stall_o(pc_st[1]), .if2id_stall_o(if_st[1]), .id2ex_stall_o(id_st[1]),
        .ex2mem_stall_o(ex_st[1]), .if2id_flush_o(if_fl[1]), .id2ex_flush_o(id_fl[1]),
        .mem2wb_flush_o(wb_fl[1]), .mem_tout_o(tout[1]),
        .stall_cnt_o(scnt[1]), .flush_cnt_o(fcnt[1])
    );

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int   m_pend   [2];   // bubbles still owed after the current cycle
    int   m_scnt   [2];
    int   m_fcnt   [2];
    int   m_consec;       // consecutive MEM wait cycles completed
    logic m_tout;
    exp_t exp_c    [2];

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic logic lu_hit_f();
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < NRP; p++)
            if (mem_to_reg && we_E && rd_E != 0 && rs_D[p*RAW +: RAW] == rd_E)
                hit = 1'b1;
        return hit;
    endfunction

    function automatic exp_t model_out(input int k);
        exp_t e;
        logic [RAW-1:0] rs;
        e = '0;
        if (!rst_n) return e;
        for (int p = 0; p < NRP; p++) begin
            rs = rs_E[p*RAW +: RAW];
            if (we_M && rd_M != 0 && rd_M == rs)      e.fwd[2*p +: 2] = 2'b01;
            else if (we_W && rd_W != 0 && rd_W == rs) e.fwd[2*p +: 2] = 2'b10;
        end
        if (mem_req && !mem_ready) begin
            e.pc_st = 1'b1; e.if_st = 1'b1; e.id_st = 1'b1; e.ex_st = 1'b1; e.wb_fl = 1'b1;
        end else if (b_taken) begin
            e.if_fl = 1'b1; e.id_fl = 1'b1;
        end else if (m_pend[k] > 0 || lu_hit_f()) begin
            e.pc_st = 1'b1; e.if_st = 1'b1; e.id_fl = 1'b1;
        end
        return e;
    endfunction

    always_comb begin
        exp_c[0] = model_out(0);
        exp_c[1] = model_out(1);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_pend[k] <= 0;
                m_scnt[k] <= 0;
                m_fcnt[k] <= 0;
            end
            m_consec <= 0;
            m_tout   <= 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (mem_req && !mem_ready)  m_pend[k] <= m_pend[k];
                else if (b_taken)           m_pend[k] <= 0;
                else if (m_pend[k] > 0)     m_pend[k] <= m_pend[k] - 1;
                else if (lu_hit_f())        m_pend[k] <= lat_of(k) - 1;
                if (exp_c[k].pc_st) m_scnt[k] <= m_scnt[k] + 1;
                if (exp_c[k].if_fl) m_fcnt[k] <= m_fcnt[k] + 1;
            end
            if (mem_req && !mem_ready) begin
                m_consec <= m_consec + 1;
                if (m_consec + 1 >= MT) m_tout <= 1'b1;
            end else begin
                m_consec <= 0;
            end
        end
    end

    function automatic logic [CW-1:0] exp_cnt(input int v);
`ifdef HAZARD_PERF_CNT_EN
        return CW'(v);
`else
        return (v < 0) ? CW'(1) : '0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Model-vs-DUT compare on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                check($sformatf("u%0d.fwd_sel", k),   32'(fwd[k]),   32'(exp_c[k].fwd));
                check($sformatf("u%0d.pc_stall", k),  32'(pc_st[k]), 32'(exp_c[k].pc_st));
                check($sformatf("u%0d.if2id_stall", k), 32'(if_st[k]), 32'(exp_c[k].if_st));
                check($sformatf("u%0d.id2ex_stall", k), 32'(id_st[k]), 32'(exp_c[k].id_st));
                check($sformatf("u%0d.ex2mem_stall", k), 32'(ex_st[k]), 32'(exp_c[k].ex_st));
                check($sformatf("u%0d.if2id_flush", k), 32'(if_fl[k]), 32'(exp_c[k].if_fl));
                check($sformatf("u%0d.id2ex_flush", k), 32'(id_fl[k]), 32'(exp_c[k].id_fl));
                check($sformatf("u%0d.mem2wb_flush", k), 32'(wb_fl[k]), 32'(exp_c[k].wb_fl));
                check($sformatf("u%0d.mem_tout", k),  32'(tout[k]),  32'(m_tout));
                check($sformatf("u%0d.stall_cnt", k), 32'(scnt[k]),  32'(exp_cnt(m_scnt[k])));
                check($sformatf("u%0d.flush_cnt", k), 32'(fcnt[k]),  32'(exp_cnt(m_fcnt[k])));
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic idle();
        rs_D = '0; rs_E = '0; rd_E = '0; rd_M = '0; rd_W = '0;
        we_E = 1'b0; we_M = 1'b0; we_W = 1'b0;
        mem_to_reg = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; b_taken = 1'b0;
    endtask

    // Load writing r7 in EX, read by ID port 1.
    task automatic load_in();
        mem_to_reg = 1'b1; we_E = 1'b1; rd_E = 5'd7;
        rs_D[0 +: RAW] = 5'd3; rs_D[RAW +: RAW] = 5'd7;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic next_cyc();
        @(posedge clk); #1;
    endtask

    initial begin
        idle();
        #1 rst_n = 1'b0;
        // Reset: inputs that would otherwise stall/flush/forward must not.
        load_in(); b_taken = 1'b1; mem_req = 1'b1;
        we_M = 1'b1; rd_M = 5'd5; rs_E[0 +: RAW] = 5'd5;
        settle();
        check("rst.pc_stall", 32'(pc_st[0]), 32'd0);
        check("rst.fwd_sel",  32'(fwd[0]),   32'd0);
        check("rst.if2id_flush", 32'(if_fl[1]), 32'd0);
        check("rst.mem2wb_flush", 32'(wb_fl[0]), 32'd0);
        next_cyc(); idle(); rst_n = 1'b1;

        // Forwarding priority and r0 exclusion.
        next_cyc();
        we_M = 1'b1; rd_M = 5'd5; we_W = 1'b1; rd_W = 5'd5; rs_E[0 +: RAW] = 5'd5;
        settle(); check("t1.m_wins", 32'(fwd[0][1:0]), 32'b01);
        next_cyc(); rd_M = 5'd0;
        settle(); check("t1.w_when_m_r0", 32'(fwd[0][1:0]), 32'b10);
        next_cyc(); rd_W = 5'd0;
        settle(); check("t1.both_r0", 32'(fwd[0][1:0]), 32'b00);
        next_cyc(); we_M = 1'b0; rd_M = 5'd9; rd_W = 5'd9; rs_E[RAW +: RAW] = 5'd9;
        settle(); check("t1.port1_w", 32'(fwd[0]), 32'b1000);

        // Load-use: two bubbles with LOAD_LAT=2, one with LOAD_LAT=1.
        next_cyc(); idle(); load_in();
        settle();
        check("t2.c1_pc_stall", 32'(pc_st[0]), 32'd1);
        check("t2.c1_id2ex_flush", 32'(id_fl[0]), 32'd1);
        check("t2.c1_lat1_stall", 32'(pc_st[1]), 32'd1);
        next_cyc(); idle();
        settle();
        check("t2.c2_pc_stall", 32'(pc_st[0]), 32'd1);
        check("t2.c2_id2ex_flush", 32'(id_fl[0]), 32'd1);
        check("t2.c2_lat1_stall", 32'(pc_st[1]), 32'd0);
        next_cyc();
        settle(); check("t2.c3_run", 32'(pc_st[0]), 32'd0);

        // Branch taken during the LU_WAIT cycle.
        next_cyc(); load_in();
        settle();
        next_cyc(); idle(); b_taken = 1'b1;
        settle();
        check("t3.if2id_flush", 32'(if_fl[0]), 32'd1);
        check("t3.id2ex_flush", 32'(id_fl[0]), 32'd1);
        check("t3.pc_stall", 32'(pc_st[0]), 32'd0);
        next_cyc(); idle();
        settle(); check("t3.back_run", 32'(pc_st[0]), 32'd0);

        // MEM freeze for 3 cycles in the middle of LU_WAIT.
        next_cyc(); load_in();
        settle();
        next_cyc(); idle(); mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t4.ex2mem_stall", 32'(ex_st[0]), 32'd1);
            check("t4.mem2wb_flush", 32'(wb_fl[0]), 32'd1);
            check("t4.id2ex_flush", 32'(id_fl[0]), 32'd0);
            next_cyc();
        end
        mem_ready = 1'b1;
        settle();
        check("t4.resume_bubble", 32'(pc_st[0]), 32'd1);
        check("t4.resume_lat1", 32'(pc_st[1]), 32'd0);
        check("t4.no_tout", 32'(tout[0]), 32'd0);
        next_cyc(); idle();
        settle(); check("t4.done", 32'(pc_st[0]), 32'd0);

        // MEM timeout after 4 consecutive wait cycles, sticky afterwards.
        next_cyc(); mem_req = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            settle();
            if (i == 3) check("t5.tout_before", 32'(tout[0]), 32'd0);
            if (i == 5) check("t5.tout_set", 32'(tout[0]), 32'd1);
            next_cyc();
        end
        mem_ready = 1'b1;
        settle(); check("t5.tout_after_ready", 32'(tout[1]), 32'd1);
        next_cyc(); idle();
        settle(); check("t5.tout_sticky", 32'(tout[0]), 32'd1);

        // Simultaneous load-use and branch: branch only.
        next_cyc(); load_in(); b_taken = 1'b1;
        settle();
        check("t7.pc_stall", 32'(pc_st[0]), 32'd0);
        check("t7.if2id_flush", 32'(if_fl[0]), 32'd1);
        next_cyc(); idle();
        settle(); check("t7.no_lu_wait", 32'(pc_st[0]), 32'd0);

        // Reset in the middle of LU_WAIT returns to RUN immediately.
        next_cyc(); load_in();
        settle();
        next_cyc(); idle();
        settle(); check("t8.in_lu_wait", 32'(pc_st[0]), 32'd1);
        rst_n = 1'b0; #2;
        check("t8.rst_stall", 32'(pc_st[0]), 32'd0);
        check("t8.rst_tout", 32'(tout[0]), 32'd0);
        next_cyc(); rst_n = 1'b1;
        settle(); check("t8.run_after_rst", 32'(pc_st[0]), 32'd0);

        // Performance counters: 3 load-use events and 2 branches.
        for (int i = 0; i < 3; i++) begin
            next_cyc(); load_in(); settle();
            next_cyc(); idle();    settle();
        end
        for (int i = 0; i < 2; i++) begin
            next_cyc(); b_taken = 1'b1; settle();
            next_cyc(); idle();         settle();
        end
`ifdef HAZARD_PERF_CNT_EN
        check("t6.lat1_stall_cnt", 32'(scnt[1]), 32'd3);
        check("t6.lat1_flush_cnt", 32'(fcnt[1]), 32'd2);
        check("t6.lat2_stall_cnt", 32'(scnt[0]), 32'd6);
        check("t6.lat2_flush_cnt", 32'(fcnt[0]), 32'd2);
`else
        check("t6.lat1_stall_cnt", 32'(scnt[1]), 32'd0);
        check("t6.lat1_flush_cnt", 32'(fcnt[1]), 32'd0);
        check("t6.lat2_stall_cnt", 32'(scnt[0]), 32'd0);
        check("t6.lat2_flush_cnt", 32'(fcnt[0]), 32'd0);
`endif

        next_cyc();
        settle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
